func_dispatch: RTL and testbench

FUNC_DISPATCH -- requirements
Module: func_dispatch

---
 rtl/func_dispatch_if.sv | 29 ++
 rtl/func_dispatch.sv | 131 +++++++++++++
 tb/tb_func_dispatch.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/func_dispatch_if.sv
// Handshake and data bundle between the dispatcher, its operand source,
// the function unit and the result sink.
interface func_dispatch_if;
  logic        in_valid_i;
  logic [7:0]  in_a_i;
  logic [7:0]  in_b_i;
  logic        in_ready_o;
  logic        func_start_o;
  logic [7:0]  func_a_o;
  logic [7:0]  func_b_o;
  logic        func_busy_i;
  logic [23:0] func_y_i;
  logic        res_valid_o;
  logic [23:0] res_y_o;
  logic        res_ready_i;
  logic [7:0]  done_cnt_o;

  // Dispatcher side
  modport slave (
    input  in_valid_i, in_a_i, in_b_i, func_busy_i, func_y_i, res_ready_i,
    output in_ready_o, func_start_o, func_a_o, func_b_o, res_valid_o, res_y_o, done_cnt_o
  );

  // Environment side (operand source, function unit, result sink)
  modport master (
    output in_valid_i, in_a_i, in_b_i, func_busy_i, func_y_i, res_ready_i,
    input  in_ready_o, func_start_o, func_a_o, func_b_o, res_valid_o, res_y_o, done_cnt_o
  );
endinterface

// File: rtl/func_dispatch.sv
// Operand FIFO feeding a single-issue function unit: pairs {a,b} are queued,
// issued one at a time, the result is held until the sink takes it, and
// completed results are counted.
module func_dispatch #(
  parameter int DEPTH = 4
) (
  input logic         clk_i,
  input logic         rst_i,
  func_dispatch_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, OUT} state_t;

  state_t state, state_nxt;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          in_ready, push, pop;
  logic [15:0]   head;

  logic          issue, capture, release_res;
  logic          start_q, res_valid_q;
  logic [7:0]    a_q, b_q, done_q;
  logic [23:0]   y_q;

  // Ready looks only at the registered count, so a pop in the same cycle
  // as a full FIFO does not open the input.
  assign in_ready = (count < FULL);
  assign push     = bus.in_valid_i && in_ready;
  assign pop      = issue;
  assign head     = mem[rd_ptr];

  // Operand storage; no reset needed since count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {bus.in_a_i, bus.in_b_i};
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Sequencer next state and one-cycle control strobes.
  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && !bus.func_busy_i) begin
          issue     = 1'b1;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // Busy must be seen high first, otherwise the old low level would
        // be mistaken for completion.
        if (bus.func_busy_i) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.func_busy_i) begin
          capture   = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (bus.res_ready_i) begin
          release_res = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs: operand launch, start pulse, result hold, completion count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      y_q         <= '0;
      done_q      <= '0;
    end else begin
      start_q <= issue;
      if (issue) begin
        a_q <= head[15:8];
        b_q <= head[7:0];
      end
      if (capture) begin
        y_q         <= bus.func_y_i;
        res_valid_q <= 1'b1;
        done_q      <= done_q + 8'd1;
      end else if (release_res) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.func_start_o = start_q;
  assign bus.func_a_o     = a_q;
  assign bus.func_b_o     = b_q;
  assign bus.res_valid_o  = res_valid_q;
  assign bus.res_y_o      = y_q;
  assign bus.done_cnt_o   = done_q;
endmodule

// File: tb/tb_func_dispatch.sv
// Scoreboard bench for func_dispatch: accepted pairs push a reference
// result (a^3 + floor(sqrt(b))) into a queue; a monitor pops and compares
// on every result handshake. A behavioural function unit answers start
// pulses after a random busy time.
module tb_func_dispatch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  func_dispatch_if bus();

  func_dispatch #(.DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [23:0] exp_q[$];
  int          done_exp = 0;

  logic        force_busy = 1'b0;
  logic        model_busy = 1'b0;
  logic [23:0] model_y    = '0;
  logic [23:0] pend_y     = '0;
  logic        start_prev = 1'b0;
  int          busy_cnt   = 0;
  int          lat_min    = 1;
  int          lat_max    = 4;
  int          rdy_mode   = 0;  // 0: always ready, 1: never ready, 2: random

  assign bus.func_busy_i = force_busy | model_busy;
  assign bus.func_y_i    = model_y;

  function automatic logic [23:0] ref_y(input logic [7:0] a, input logic [7:0] b);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= int'(b)) r++;
    return 24'(int'(a) * int'(a) * int'(a) + r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Behavioural function unit: busy for a random time after each start.
  always @(negedge clk) begin
    if (bus.func_start_o) begin
      chk("one_in_flight", 32'(model_busy), 32'd0);
      chk("start_width", 32'(start_prev), 32'd0);
      pend_y     = ref_y(bus.func_a_o, bus.func_b_o);
      model_busy = 1'b1;
      busy_cnt   = $urandom_range(lat_max, lat_min);
    end else if (model_busy) begin
      if (busy_cnt <= 1) begin
        model_busy = 1'b0;
        model_y    = pend_y;
      end else begin
        busy_cnt--;
      end
    end
    start_prev = bus.func_start_o;
  end

  // Result sink ready pattern.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.res_ready_i = 1'b1;
      1:       bus.res_ready_i = 1'b0;
      default: bus.res_ready_i = 1'($urandom_range(1, 0));
    endcase
  end

  // Scoreboard: enqueue on accepted push, compare on result handshake.
  always @(negedge clk) begin
    if (!rst && bus.in_valid_i && bus.in_ready_o)
      exp_q.push_back(ref_y(bus.in_a_i, bus.in_b_i));
    if (!rst && bus.res_valid_o && bus.res_ready_i) begin
      done_exp++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL res_unexpected: got %0h expected no result", bus.res_y_o);
      end else begin
        chk("res_y", 32'(bus.res_y_o), 32'(exp_q.pop_front()));
      end
      chk("done_cnt", 32'(bus.done_cnt_o), 32'(done_exp % 256));
    end
  end

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_a_i     = a;
    bus.in_b_i     = b;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready_o;
    end
    if (!acc) fail_now("push_accept");
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && !bus.res_valid_o && !bus.func_busy_i;
    end
    if (!ok) fail_now("drain");
    @(posedge clk); #1;
  endtask

  task automatic wait_res_valid(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = bus.res_valid_o;
    end
    if (!ok) fail_now(name);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"},     32'(bus.func_start_o), 32'd0);
    chk({tag, "_a"},         32'(bus.func_a_o),     32'd0);
    chk({tag, "_b"},         32'(bus.func_b_o),     32'd0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid_o),  32'd0);
    chk({tag, "_res_y"},     32'(bus.res_y_o),      32'd0);
    chk({tag, "_done_cnt"},  32'(bus.done_cnt_o),   32'd0);
    chk({tag, "_in_ready"},  32'(bus.in_ready_o),   32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    bus.in_valid_i  = 1'b0;
    bus.in_a_i      = '0;
    bus.in_b_i      = '0;
    bus.res_ready_i = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Single op (2,16): 8 + 4 = 12, start exactly two edges after the push edge
    push_pair(8'd2, 8'd16);
    @(negedge clk);
    chk("latency_early", 32'(bus.func_start_o), 32'd0);
    @(negedge clk);
    chk("latency_start", 32'(bus.func_start_o), 32'd1);
    chk("issue_a", 32'(bus.func_a_o), 32'd2);
    chk("issue_b", 32'(bus.func_b_o), 32'd16);
    wait_res_valid("first_result");
    chk("first_res_y", 32'(bus.res_y_o), 32'd12);
    chk("first_done", 32'(bus.done_cnt_o), 32'd1);
    wait_idle();

    // Fill with busy held, 5th pair refused, then full + pop cycle rejects
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_pair(8'($urandom), 8'($urandom));
    @(negedge clk);
    chk("full_ready", 32'(bus.in_ready_o), 32'd0);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b1;
    bus.in_a_i     = 8'($urandom);
    bus.in_b_i     = 8'($urandom);
    repeat (5) begin
      @(negedge clk);
      chk("fifth_refused", 32'(bus.in_ready_o), 32'd0);
    end
    @(posedge clk); #1;
    force_busy = 1'b0;
    @(negedge clk);
    chk("full_pop_reject", 32'(bus.in_ready_o), 32'd0);
    @(negedge clk);
    chk("accept_next", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    wait_idle();

    // Sink stalls in OUT: result holds, nothing new issues
    rdy_mode = 1;
    @(posedge clk); #1;
    push_pair(8'($urandom), 8'($urandom));
    wait_res_valid("stall_result");
    push_pair(8'($urandom), 8'($urandom));
    repeat (10) begin
      @(negedge clk);
      chk("stall_res_y", 32'(bus.res_y_o), 32'(exp_q[0]));
      chk("stall_no_start", 32'(bus.func_start_o), 32'd0);
      chk("stall_valid", 32'(bus.res_valid_o), 32'd1);
    end
    rdy_mode = 0;
    wait_idle();

    // Reset during WAIT_DONE with 3 pairs queued
    lat_min = 30;
    lat_max = 30;
    for (int i = 0; i < 4; i++) push_pair(8'($urandom), 8'($urandom));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    exp_q.delete();
    done_exp = 0;
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      chk("midrst_no_result", 32'(bus.res_valid_o), 32'd0);
    end
    chk("midrst_done", 32'(bus.done_cnt_o), 32'd0);
    chk("midrst_ready", 32'(bus.in_ready_o), 32'd1);
    lat_min = 1;
    lat_max = 4;
    @(posedge clk); #1;

    // 256 random ops with random sink readiness: counter wraps to 0
    rdy_mode = 2;
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i == 0) begin ra = 8'd255; rb = 8'd255; end
      push_pair(ra, rb);
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
    end
    wait_idle();
    rdy_mode = 0;
    chk("wrap_done_cnt", 32'(bus.done_cnt_o), 32'd0);
    chk("wrap_count", 32'(done_exp), 32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
